// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// funct3 codes, FSM encoding and the request legality check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Unsigned variants only make sense for loads.
    function automatic logic is_legal(
        input logic       we,
        input logic [2:0] funct3
    );
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32 loads and stores.
// Builds byte enables, shifted store data, extended load data.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic [7:0]  rb;
    logic [15:0] rh;

    assign is_b = (funct3[1:0] == 2'b00);
    assign is_h = (funct3[1:0] == 2'b01);
    assign is_w = (funct3[1:0] == 2'b10);

    assign rb = rword[{lane, 3'b000} +: 8];
    assign rh = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be       = 4'b0000;
        wdata_sh = 32'h0;
        misalign = 1'b0;
        unique case (1'b1)
            is_b: begin
                be       = 4'b0001 << lane;
                wdata_sh = {4{wdata[7:0]}};
            end
            is_h: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
                misalign = lane[0];
            end
            is_w: begin
                be       = 4'b1111;
                wdata_sh = wdata;
                misalign = (lane != 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata = 32'h0;
        case (funct3)
            F3_B:    rdata = {{24{rb[7]}}, rb};
            F3_BU:   rdata = {24'h0, rb};
            F3_H:    rdata = {{16{rh[15]}}, rh};
            F3_HU:   rdata = {16'h0, rh};
            F3_W:    rdata = rword;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: latched request, fixed
// latency countdown, single access, held response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;

    logic            r_we;
    logic [2:0]      r_f3;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;

    logic [31:0]     rdata_q;
    logic            err_q;

    logic [31:0]     mem [DEPTH];

    logic [AW-1:0]   idx;
    logic            oor;
    logic [3:0]      be;
    logic [31:0]     wdata_sh;
    logic [31:0]     ld_data;
    logic            misalign;
    logic            err;
    logic            accept;
    logic            access;
    logic            done;

    assign idx    = r_addr[AW+1:2];
    assign oor    = |r_addr[31:AW+2];
    assign err    = ~is_legal(r_we, r_f3) | misalign | oor;
    assign accept = (state == IDLE) & req_valid;
    assign access = (state == WAIT) & (cnt == '0);
    assign done   = (state == RESP) & resp_ready;

    dmem_lane_align u_align (
        .funct3   (r_f3),
        .lane     (r_addr[1:0]),
        .wdata    (r_wdata),
        .rword    (mem[idx]),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (ld_data),
        .misalign (misalign)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            r_we    <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (access) begin
                rdata_q <= (err | r_we) ? 32'h0 : ld_data;
                err_q   <= err;
            end else if (done) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (access & r_we & ~err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-level
// memory model with directed lane, error and reset cases.
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    bit [31:0] mdl [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory as a byte array view: sizes, alignment and range
    // are judged arithmetically on the byte address.
    function automatic void model(input bit we, input bit [2:0] f3,
                                  input bit [31:0] a, input bit [31:0] wd,
                                  output bit [31:0] rd, output bit er);
        int  size;
        bit  sgn;
        int  w;
        int  off;
        longint v;
        longint mask;
        rd = 0;
        er = 0;
        sgn = 0;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: size = 4;
            3'd4: size = we ? 0 : 1;
            3'd5: size = we ? 0 : 2;
            default: size = 0;
        endcase
        if (size == 0 || (a % size) != 0 || longint'(a) >= DEPTH * 4) begin
            er = 1;
            return;
        end
        w = int'(a / 4);
        off = int'(a % 4);
        if (we) begin
            for (int k = 0; k < size; k++)
                mdl[w][8*(off+k) +: 8] = wd[8*k +: 8];
            return;
        end
        mask = (64'd1 << (8 * size)) - 1;
        v = (longint'(mdl[w]) >> (8 * off)) & mask;
        if (sgn && size < 4 && v >= (mask + 1) / 2)
            v = v - (mask + 1);
        rd = v[31:0];
    endfunction

    task automatic run(input bit we, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input int hold, input string tag,
                       output bit [31:0] rd, output bit er);
        bit [31:0] erd;
        bit        eer;
        int        n;
        int        lat;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 50);
        model(we, f3, a, wd, erd, eer);
        rd = resp_rdata;
        er = resp_err;
        check({tag, "_lat"}, 32'(lat), 32'(LATENCY + 1));
        check({tag, "_rdata"}, resp_rdata, erd);
        check({tag, "_err"}, {31'b0, resp_err}, {31'b0, eer});
        check({tag, "_rdy_in_resp"}, {31'b0, req_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            req_valid = h[0];
            req_addr  = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
            req_we    = 1'b1;
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'b0, resp_valid}, 32'd1);
            check({tag, "_hold_rdata"}, resp_rdata, erd);
            check({tag, "_hold_err"}, {31'b0, resp_err}, {31'b0, eer});
            check({tag, "_hold_rdy"}, {31'b0, req_ready}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_post_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_post_rdata"}, resp_rdata, 32'd0);
        check({tag, "_post_err"}, {31'b0, resp_err}, 32'd0);
        check({tag, "_post_rdy"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        bit [31:0] rd;
        bit        er;
        bit        seen;
        bit [31:0] a;
        bit [2:0]  f3;
        int        sel;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);

        for (int i = 0; i < DEPTH; i++)
            run(1'b1, 3'd2, 32'(i * 4), $urandom, 0, "init", rd, er);

        run(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, "sw10", rd, er);
        run(1'b0, 3'd2, 32'h10, 32'h0, 0, "lw10", rd, er);
        check("lw10_const", rd, 32'hDEADBEEF);
        run(1'b1, 3'd0, 32'h11, 32'h000000AA, 0, "sb11", rd, er);
        run(1'b0, 3'd2, 32'h10, 32'h0, 0, "lw10b", rd, er);
        check("lw10b_const", rd, 32'hDEADAAEF);
        run(1'b0, 3'd0, 32'h13, 32'h0, 0, "lb13", rd, er);
        check("lb13_const", rd, 32'hFFFFFFDE);
        run(1'b0, 3'd4, 32'h13, 32'h0, 0, "lbu13", rd, er);
        check("lbu13_const", rd, 32'h000000DE);
        run(1'b0, 3'd1, 32'h12, 32'h0, 0, "lh12", rd, er);
        check("lh12_const", rd, 32'hFFFFDEAD);

        run(1'b0, 3'd2, 32'h12, 32'h0, 0, "lw12_mis", rd, er);
        check("lw12_err_const", {31'b0, er}, 32'd1);
        run(1'b1, 3'd1, 32'h11, 32'h5555, 0, "sh11_mis", rd, er);
        check("sh11_err_const", {31'b0, er}, 32'd1);
        run(1'b0, 3'd2, 32'h10, 32'h0, 0, "lw10c", rd, er);
        check("lw10c_const", rd, 32'hDEADAAEF);
        run(1'b0, 3'd2, 32'h400, 32'h0, 0, "lw400_oor", rd, er);
        check("lw400_err_const", {31'b0, er}, 32'd1);
        run(1'b0, 3'd3, 32'h10, 32'h0, 0, "f3_011", rd, er);
        check("f3_011_err_const", {31'b0, er}, 32'd1);
        run(1'b1, 3'd4, 32'h10, 32'h0, 0, "sbu_ill", rd, er);

        run(1'b0, 3'd2, 32'h10, 32'h0, 5, "bp", rd, er);
        check("bp_const", rd, 32'hDEADAAEF);

        run(1'b1, 3'd2, 32'h20, 32'h0, 0, "sw20_zero", rd, er);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("midrst_no_resp", {31'b0, seen}, 32'd0);
        check("midrst_ready", {31'b0, req_ready}, 32'd1);
        run(1'b0, 3'd2, 32'h20, 32'h0, 0, "lw20", rd, er);
        check("lw20_const", rd, 32'h0);

        for (int t = 0; t < 300; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)
                a = $urandom_range(0, DEPTH * 4 - 1);
            else if (sel == 8)
                a = $urandom_range(DEPTH * 4 - 4, DEPTH * 4 + 3);
            else
                a = $urandom;
            f3 = 3'($urandom_range(0, 7));
            run(1'($urandom_range(0, 1)), f3, a, $urandom,
                ($urandom_range(0, 9) == 0) ? 2 : 0, "rnd", rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that serves load/store requests issued by the RISC-V core's datapath. The core drives the address (ALU result), the store data and funct3; this block answers with read data.
- Valid/ready request and response handshakes.
- Programmable access latency.
- RV32 byte/half/word lane handling with sign/zero extension.
- Error flagging for misaligned, out-of-range or illegal accesses.

It sits between the pipeline's MEM stage and a word-organised internal RAM array.

Parameters:
DEPTH, 256, number of 32-bit words in the array (power of two, >=4)
LATENCY, 2, cycles spent in WAIT before a response is presented (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (reset=0 resets the block)
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32 load/store funct3
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  load data, extended; 0 for stores and errors
resp_err  output  1  access faulted

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Array contents are not cleared.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we/funct3/addr/wdata, load counter=LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter==0, perform the access and go to RESP.
  - Request-to-resp_valid latency is LATENCY+1 cycles after the accept edge.
- Access rules:
  - Word index = addr[log2(DEPTH)+1:2].
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101. Byte lane is addr[1:0]; half lane is addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
  - Stores: SB=000, SH=001, SW=010. Only the addressed bytes are written; other bytes in the word are preserved.
- Error conditions, evaluated at the access cycle:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr[31:log2(DEPTH)+2] != 0 (out of range);
  - illegal funct3 (011, 110, 111 for either direction; 100/101 with we=1).
  - On error: no array write, resp_err=1, resp_rdata=0.
- RESP:
  - resp_valid=1.
  - resp_rdata and resp_err are held stable until resp_ready=1.
  - On resp_valid&resp_ready, go to IDLE. resp_valid drops the next cycle; resp_rdata and resp_err return to 0.
- A new request cannot be accepted in the same cycle as the response handshake; req_ready rises one cycle after the handshake.
- Load after store to the same word returns the newly written data.
- req_valid ignored while not in IDLE; no request queueing.
- Reset asserted mid-WAIT or mid-RESP:
  - Transaction abandoned, no response issued.
  - A store whose access cycle has not yet occurred is not performed.
- Counter width is clog2(LATENCY)+1. LATENCY=1 means WAIT lasts exactly one cycle.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encoding IDLE/WAIT/RESP (2-bit);
  - function is_legal(we, funct3).
- Sub-module dmem_lane_align, purely combinational:
  - store path: produces 4-bit byte enables and lane-shifted write data from funct3/addr[1:0]/wdata;
  - load path: extracts and extends from the read word;
  - misalignment detection.
- Top module holds the FSM, counter, request latches and array.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 with LATENCY=2 -> resp_valid exactly 3 cycles after each accept; load resp_rdata=0xDEADBEEF, resp_err=0.
- Lane handling, after SW 0x10=0xDEADBEEF:
  - SB 0x11 data 0x000000AA -> subsequent LW 0x10 returns 0xDEADAAEF;
  - LB 0x13 returns 0xFFFFFFDE;
  - LBU 0x13 returns 0x000000DE;
  - LH 0x12 returns 0xFFFFDEAD.
- Errors:
  - LW 0x12 -> resp_err=1, resp_rdata=0;
  - SH 0x11 -> resp_err=1 and the word is unchanged;
  - LW 0x400 (DEPTH=256) -> resp_err=1;
  - funct3=011 -> resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles during RESP -> resp_valid, resp_rdata and resp_err stable; req_ready=0 throughout; req_valid pulses are ignored.
- Reset mid-WAIT on SW 0x20=0x12345678 (prior value 0) -> no response; after release, LW 0x20 returns 0.
